// File: rtl/craps_dice_roller.sv
// Two-dice roller for the craps game: a roll button edge starts a tumble of
// LFSR-driven dice, then the final faces latch into sum (and into point on come-out).
module craps_dice_roller #(
  parameter int unsigned TUMBLE_CYCLES = 16,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       roll,
  input  logic [1:0] game_op,
  output logic [2:0] die1,
  output logic [2:0] die2,
  output logic [3:0] sum,
  output logic [3:0] point,
  output logic       roll_done,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, TUMBLE, LATCH} state_t;

  localparam logic [7:0] CNT_LOAD = 8'(TUMBLE_CYCLES - 1);
  localparam logic [1:0] OP_REROLL = 2'b01;

  state_t      state, state_nxt;
  logic [7:0]  cnt, cnt_nxt;
  logic [15:0] lfsr;
  logic        roll_q;
  logic        req;
  logic [2:0]  c1, c2;
  logic        c1_ok, c2_ok;
  logic [3:0]  throw_sum;

  assign req       = roll & ~roll_q;
  assign c1        = lfsr[2:0];
  assign c2        = lfsr[5:3];
  // Candidates 0 and 7 are rejected so a die can never show an illegal face.
  assign c1_ok     = (c1 != 3'd0) && (c1 != 3'd7);
  assign c2_ok     = (c2 != 3'd0) && (c2 != 3'd7);
  assign throw_sum = {1'b0, die1} + {1'b0, die2};
  assign busy      = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= 8'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (req) begin
          state_nxt = TUMBLE;
          cnt_nxt   = CNT_LOAD;
        end
      end
      TUMBLE: begin
        if (cnt == 8'd0) state_nxt = LATCH;
        else             cnt_nxt   = cnt - 8'd1;
      end
      LATCH:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr      <= LFSR_SEED;
      roll_q    <= 1'b0;
      die1      <= 3'd1;
      die2      <= 3'd1;
      sum       <= 4'd0;
      point     <= 4'd0;
      roll_done <= 1'b0;
    end else begin
      lfsr      <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      roll_q    <= roll;
      roll_done <= (state == LATCH);
      if (state == TUMBLE) begin
        if (c1_ok) die1 <= c1;
        if (c2_ok) die2 <= c2;
      end
      // Point is only re-established outside a reroll round.
      if (state == LATCH) begin
        sum <= throw_sum;
        if (game_op != OP_REROLL) point <= throw_sum;
      end
    end
  end

endmodule

// File: tb/tb_craps_dice_roller.sv
// Scoreboard bench for craps_dice_roller: stimulus predicts each throw with an
// independent LFSR/dice model; a monitor pops and compares on every roll_done.
module tb_craps_dice_roller;
  localparam int          T    = 4;
  localparam logic [15:0] SEED = 16'hACE1;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       roll = 1'b0;
  logic [1:0] game_op = 2'b00;
  logic [2:0] die1, die2;
  logic [3:0] sum, point;
  logic       roll_done, busy;

  craps_dice_roller #(.TUMBLE_CYCLES(T), .LFSR_SEED(SEED)) dut (
    .clk(clk), .reset(reset), .roll(roll), .game_op(game_op),
    .die1(die1), .die2(die2), .sum(sum), .point(point),
    .roll_done(roll_done), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] sum;
    logic [3:0] point;
    logic [2:0] d1;
    logic [2:0] d2;
    int         due;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [15:0] m_lfsr;
  logic [2:0]  m_d1 = 3'd1;
  logic [2:0]  m_d2 = 3'd1;
  logic [3:0]  m_point = 4'd0;

  function automatic logic [15:0] step(input logic [15:0] l);
    logic fb;
    fb = l[15] ^ l[13] ^ l[12] ^ l[10];
    return {l[14:0], fb};
  endfunction

  always @(posedge clk) begin
    cyc    <= cyc + 1;
    m_lfsr <= reset ? SEED : step(m_lfsr);
  end

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s got %0d want %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Called at a negedge just before the request edge E0; dice at E1..E_T use
  // the LFSR states L1..L_T, the latch lands at E_{T+1}.
  task automatic predict(input logic [1:0] op);
    logic [15:0] l;
    exp_t        e;
    l = m_lfsr;
    for (int k = 0; k < T; k++) begin
      l = step(l);
      if (l[2:0] >= 3'd1 && l[2:0] <= 3'd6) m_d1 = l[2:0];
      if (l[5:3] >= 3'd1 && l[5:3] <= 3'd6) m_d2 = l[5:3];
    end
    e.sum = {1'b0, m_d1} + {1'b0, m_d2};
    if (op != 2'b01) m_point = e.sum;
    e.point = m_point;
    e.d1    = m_d1;
    e.d2    = m_d2;
    e.due   = cyc + T + 2;
    q.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      check("die1_range", int'(die1 >= 3'd1 && die1 <= 3'd6), 1);
      check("die2_range", int'(die2 >= 3'd1 && die2 <= 3'd6), 1);
      if (roll_done) begin
        if (q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          e = q.pop_front();
          check("sum", sum, e.sum);
          check("point", point, e.point);
          check("die1", die1, e.d1);
          check("die2", die2, e.d2);
          check("latency_cycle", cyc, e.due);
          check("busy_at_done", busy, 0);
        end
      end
    end
  end

  task automatic wait_done();
    int n;
    n = 0;
    while (!roll_done && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!roll_done) check("done_timeout", 0, 1);
  endtask

  task automatic throw_once(input logic [1:0] op);
    @(negedge clk);
    game_op = op;
    roll    = 1'b1;
    predict(op);
    @(negedge clk);
    check("busy_after_req", busy, 1);
    roll = 1'b0;
    wait_done();
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_die1"}, die1, 1);
    check({tag, "_die2"}, die2, 1);
    check({tag, "_sum"}, sum, 0);
    check({tag, "_point"}, point, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, roll_done, 0);
  endtask

  initial begin
    logic [3:0] p;
    // Reset for two clocks
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_vals("reset");
    reset = 1'b0;

    // Come-out throws under init, win and lose, then a reroll throw
    throw_once(2'b00);
    throw_once(2'b10);
    throw_once(2'b11);
    throw_once(2'b00);
    p = point;
    throw_once(2'b01);
    check("point_hold", point, p);

    // Second rising edge of roll at E2 while busy is dropped
    @(negedge clk);
    game_op = 2'b00;
    roll    = 1'b1;
    predict(2'b00);
    @(negedge clk) roll = 1'b0;
    @(negedge clk) roll = 1'b1;
    @(negedge clk) roll = 1'b0;
    wait_done();

    // Holding roll for 20 cycles yields one throw
    @(negedge clk);
    roll = 1'b1;
    predict(2'b00);
    repeat (20) @(negedge clk);
    roll = 1'b0;
    repeat (4) @(negedge clk);
    check("idle_after_hold", busy, 0);

    // A request raised in the roll_done cycle is accepted
    @(negedge clk);
    game_op = 2'b10;
    roll    = 1'b1;
    predict(2'b10);
    @(negedge clk) roll = 1'b0;
    wait_done();
    roll = 1'b1;
    predict(2'b10);
    @(negedge clk);
    check("busy_back_to_back", busy, 1);
    roll = 1'b0;
    wait_done();

    // Reset sampled at E2 of a tumble aborts the throw
    @(negedge clk) roll = 1'b1;
    @(negedge clk) roll = 1'b0;
    @(negedge clk) reset = 1'b1;
    @(negedge clk);
    check_reset_vals("midreset");
    reset   = 1'b0;
    m_d1    = 3'd1;
    m_d2    = 3'd1;
    m_point = 4'd0;
    repeat (T + 4) @(negedge clk);
    check("no_done_after_abort", int'(q.size()), 0);
    throw_once(2'b00);

    // Volume run with arbitrary game states
    for (int i = 0; i < 200; i++) throw_once(2'($urandom_range(0, 3)));

    repeat (5) @(negedge clk);
    check("queue_empty", int'(q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
